// File: rtl/bnnroll_hs_classifier.sv
// bnnroll_hs_classifier: rolled one-hidden-layer binary neural network classifier with valid/ready handshakes
module bnnroll_hs_classifier #(
  parameter int FEAT_CNT = 16,
  parameter int FEAT_BITS = 4,
  parameter int HIDDEN_CNT = 40,
  parameter int CLASS_CNT = 10,
  parameter int HSUM_BITS = $clog2(FEAT_CNT * (2 ** FEAT_BITS - 1) + 1),
  parameter int SUM_BITS = $clog2(HIDDEN_CNT + 1),
  parameter int CLS_BITS = $clog2(CLASS_CNT),
  parameter logic [HIDDEN_CNT*FEAT_CNT-1:0] W0 = '0,
  parameter logic [HIDDEN_CNT*HSUM_BITS-1:0] HTHR = '0,
  parameter logic [CLASS_CNT*HIDDEN_CNT-1:0] W1 = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [FEAT_BITS*FEAT_CNT-1:0] features,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [CLS_BITS-1:0]           prediction,
  output logic [SUM_BITS-1:0]           score,
  output logic                          out_valid,
  input  logic                          out_ready
);
  typedef enum logic [1:0] {IDLE, HID, CLS, DONE} state_t;
  state_t state, state_n;
  logic [FEAT_BITS*FEAT_CNT-1:0] feat_q;
  logic [SUM_BITS-1:0] hidx, s, best_s, best_s_n;
  logic [CLS_BITS-1:0] cidx, best_c, best_c_n;
  logic [HIDDEN_CNT-1:0] hbit, match;
  logic [HSUM_BITS-1:0] pre;
  logic [FEAT_BITS-1:0] xf;
  logic hid_last, cls_last, hit, better;
  assign hid_last = hidx == SUM_BITS'(HIDDEN_CNT - 1);
  assign cls_last = cidx == CLS_BITS'(CLASS_CNT - 1);
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    pre = '0;
    xf = '0;
    for (int f = 0; f < FEAT_CNT; f++) begin
      xf = W0[hidx*FEAT_CNT + f] ? feat_q[f*FEAT_BITS +: FEAT_BITS] : ~feat_q[f*FEAT_BITS +: FEAT_BITS];
      pre = pre + HSUM_BITS'(xf);
    end
    hit = pre >= HTHR[hidx*HSUM_BITS +: HSUM_BITS];
    match = ~(W1[cidx*HIDDEN_CNT +: HIDDEN_CNT] ^ hbit);
    s = '0;
    for (int h = 0; h < HIDDEN_CNT; h++) s = s + SUM_BITS'(match[h]);
    // strict compare keeps the lowest class index on ties
    better = cidx == '0 || s > best_s;
    best_s_n = better ? s : best_s;
    best_c_n = better ? cidx : best_c;
  end
  always_comb begin
    state_n = state == IDLE ? (in_valid ? HID : IDLE)
            : state == HID ? (hid_last ? CLS : HID)
            : state == CLS ? (cls_last ? DONE : CLS)
            : (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      feat_q <= '0;
      hidx <= '0;
      cidx <= '0;
      hbit <= '0;
      best_s <= '0;
      best_c <= '0;
      prediction <= '0;
      score <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        feat_q <= features;
        hidx <= '0;
      end
      if (state == HID) begin
        hbit[hidx] <= hit;
        hidx <= hid_last ? '0 : hidx + 1'b1;
        cidx <= '0;
      end
      if (state == CLS) begin
        best_s <= best_s_n;
        best_c <= best_c_n;
        cidx <= cls_last ? '0 : cidx + 1'b1;
        if (cls_last) begin
          prediction <= best_c_n;
          score <= best_s_n;
        end
      end
    end
  end
endmodule

// File: tb/tb_bnnroll_hs_classifier.sv
// tb_bnnroll_hs_classifier: randomized bench for the rolled BNN classifier against an arithmetic reference model
module tb_bnnroll_hs_classifier;
  localparam int FC = 16, FB = 4, HC = 40, CC = 10, HB = 8;
  localparam int LAT = HC + CC + 1;
  localparam int PERIOD = HC + CC + 2;

  function automatic logic [1023:0] rnd_bits(input int unsigned seed);
    logic [1023:0] r;
    int unsigned st;
    st = seed;
    r = '0;
    for (int i = 0; i < 1024; i++) begin
      st = st * 32'd1664525 + 32'd1013904223;
      r[i] = st[31];
    end
    return r;
  endfunction

  function automatic logic [HC*HB-1:0] thr_bits(input int unsigned seed, input int base, input int span);
    logic [HC*HB-1:0] r;
    int unsigned st;
    st = seed;
    r = '0;
    for (int h = 0; h < HC; h++) begin
      st = st * 32'd1664525 + 32'd1013904223;
      r[h*HB +: HB] = HB'(base + (span == 0 ? 0 : int'((st >> 16) % span)));
    end
    return r;
  endfunction

  localparam logic [1023:0] RA = rnd_bits(32'd11);
  localparam logic [1023:0] RB = rnd_bits(32'd29);
  localparam logic [CC*HC-1:0] ROW = {{(CC*HC-HC){1'b0}}, {HC{1'b1}}};
  localparam logic [HC*FC-1:0] W0_R = RA[HC*FC-1:0];
  localparam logic [HC*HB-1:0] TH_R = thr_bits(32'd7, 100, 40);
  localparam logic [CC*HC-1:0] W1_R = RB[CC*HC-1:0];
  localparam logic [HC*FC-1:0] W0_ONE = {(HC*FC){1'b1}};
  localparam logic [HC*FC-1:0] W0_ZERO = '0;
  localparam logic [HC*HB-1:0] TH_ZERO = '0;
  localparam logic [HC*HB-1:0] TH_ONE = thr_bits(32'd1, 1, 0);
  localparam logic [CC*HC-1:0] W1_A = ROW << (3 * HC);
  localparam logic [CC*HC-1:0] W1_T = RB[1023:1024-CC*HC] | (ROW << (2 * HC)) | (ROW << (7 * HC));
  localparam logic [CC*HC-1:0] W1_Z = ~ROW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [FC*FB-1:0] feat [4];
  logic [3:0] iv, ordy, ir, ov;
  logic [3:0] pred [4];
  logic [5:0] scr [4];
  int n_cmp = 0, n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bnnroll_hs_classifier #(.W0(W0_R), .HTHR(TH_R), .W1(W1_R)) dut_r (
    .clk(clk), .rst(rst), .features(feat[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .prediction(pred[0]), .score(scr[0]), .out_valid(ov[0]), .out_ready(ordy[0]));
  bnnroll_hs_classifier #(.W0(W0_ONE), .HTHR(TH_ZERO), .W1(W1_A)) dut_a (
    .clk(clk), .rst(rst), .features(feat[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .prediction(pred[1]), .score(scr[1]), .out_valid(ov[1]), .out_ready(ordy[1]));
  bnnroll_hs_classifier #(.W0(W0_ONE), .HTHR(TH_ZERO), .W1(W1_T)) dut_t (
    .clk(clk), .rst(rst), .features(feat[2]), .in_valid(iv[2]), .in_ready(ir[2]),
    .prediction(pred[2]), .score(scr[2]), .out_valid(ov[2]), .out_ready(ordy[2]));
  bnnroll_hs_classifier #(.W0(W0_ZERO), .HTHR(TH_ONE), .W1(W1_Z)) dut_z (
    .clk(clk), .rst(rst), .features(feat[3]), .in_valid(iv[3]), .in_ready(ir[3]),
    .prediction(pred[3]), .score(scr[3]), .out_valid(ov[3]), .out_ready(ordy[3]));

  function automatic void model(input logic [FC*FB-1:0] x, input logic [HC*FC-1:0] w0,
                                input logic [HC*HB-1:0] th, input logic [CC*HC-1:0] w1,
                                output int pc, output int sc);
    logic [HC-1:0] hb;
    int pre, m, v;
    for (int h = 0; h < HC; h++) begin
      pre = 0;
      for (int f = 0; f < FC; f++) begin
        v = int'(x[f*FB +: FB]);
        pre += w0[h*FC + f] ? v : 15 - v;
      end
      hb[h] = pre >= int'(th[h*HB +: HB]);
    end
    pc = 0;
    sc = -1;
    for (int c = 0; c < CC; c++) begin
      m = 0;
      for (int h = 0; h < HC; h++) m += (w1[c*HC + h] == hb[h]) ? 1 : 0;
      if (m > sc) begin
        sc = m;
        pc = c;
      end
    end
  endfunction

  task automatic transact(input int k, input logic [FC*FB-1:0] x, output int lat, output int p, output int s);
    int w = 0;
    while (!ir[k] && w < 200) begin
      @(negedge clk);
      w++;
    end
    feat[k] = x;
    iv[k] = 1'b1;
    @(negedge clk);
    iv[k] = 1'b0;
    lat = 1;
    while (!ov[k] && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    p = int'(pred[k]);
    s = int'(scr[k]);
  endtask

  task automatic test_reset;
    for (int k = 0; k < 4; k++) begin
      n_cmp += 3;
      if ({ir[k], ov[k]} !== 2'b10) begin
        n_bad++;
        $display("FAIL reset_hs k=%0d got in_ready/out_valid=%b%b want 10", k, ir[k], ov[k]);
      end
      if (pred[k] !== 4'd0) begin
        n_bad++;
        $display("FAIL reset_pred k=%0d got %0d want 0", k, pred[k]);
      end
      if (scr[k] !== 6'd0) begin
        n_bad++;
        $display("FAIL reset_score k=%0d got %0d want 0", k, scr[k]);
      end
    end
  endtask

  task automatic check_const(input string name, input int k, input int n, input int ep, input int es);
    int lat, p, s;
    for (int i = 0; i < n; i++) begin
      transact(k, k == 3 ? '1 : {$urandom, $urandom}, lat, p, s);
      n_cmp += 3;
      if (p != ep) begin
        n_bad++;
        $display("FAIL %s_pred got %0d want %0d", name, p, ep);
      end
      if (s != es) begin
        n_bad++;
        $display("FAIL %s_score got %0d want %0d", name, s, es);
      end
      if (lat != LAT) begin
        n_bad++;
        $display("FAIL %s_latency got %0d want %0d", name, lat, LAT);
      end
    end
  endtask

  task automatic test_basic;
    check_const("basic", 1, 3, 3, HC);
  endtask

  task automatic test_tie;
    check_const("tie", 2, 2, 2, HC);
  endtask

  task automatic test_zero;
    check_const("zero", 3, 2, 0, HC);
  endtask

  task automatic test_random_one(input string name, input logic [FC*FB-1:0] x);
    int lat, p, s, ep, es;
    model(x, W0_R, TH_R, W1_R, ep, es);
    transact(0, x, lat, p, s);
    n_cmp += 3;
    if (p != ep || s != es) begin
      n_bad++;
      $display("FAIL %s_result got pred=%0d score=%0d want pred=%0d score=%0d", name, p, s, ep, es);
    end
    if (lat != LAT) begin
      n_bad++;
      $display("FAIL %s_latency got %0d want %0d", name, lat, LAT);
    end
    if (ov[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_valid got %b want 1", name, ov[0]);
    end
  endtask

  task automatic test_stall;
    int p, s;
    ordy[0] = 1'b0;
    test_random_one("stall", {$urandom, $urandom});
    p = int'(pred[0]);
    s = int'(scr[0]);
    for (int i = 0; i < 20; i++) begin
      feat[0] = {$urandom, $urandom};
      iv[0] = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || int'(pred[0]) != p || int'(scr[0]) != s) begin
        n_bad++;
        $display("FAIL stall_hold cyc=%0d got ov=%b ir=%b pred=%0d score=%0d want ov=1 ir=0 pred=%0d score=%0d",
                 i, ov[0], ir[0], pred[0], scr[0], p, s);
      end
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || int'(pred[0]) != p) begin
      n_bad++;
      $display("FAIL stall_release got ov=%b ir=%b pred=%0d want ov=0 ir=1 pred=%0d", ov[0], ir[0], pred[0], p);
    end
    test_random_one("after_stall", {$urandom, $urandom});
  endtask

  task automatic test_abort;
    int seen = 0;
    @(negedge clk);
    feat[0] = {$urandom, $urandom};
    iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || pred[0] !== 4'd0 || scr[0] !== 6'd0) begin
      n_bad++;
      $display("FAIL abort_reset got ov=%b ir=%b pred=%0d score=%0d want ov=0 ir=1 pred=0 score=0",
               ov[0], ir[0], pred[0], scr[0]);
    end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ov[0]) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++;
      $display("FAIL abort_discard got %0d valid cycles want 0", seen);
    end
    test_random_one("after_abort", {$urandom, $urandom});
  endtask

  task automatic test_back_to_back;
    int lat, p, s, ep, es, prev;
    logic [FC*FB-1:0] x;
    prev = 0;
    for (int i = 0; i < 500; i++) begin
      x = {$urandom, $urandom};
      model(x, W0_R, TH_R, W1_R, ep, es);
      transact(0, x, lat, p, s);
      n_cmp += 2;
      if (p != ep || s != es) begin
        n_bad++;
        $display("FAIL b2b_result i=%0d got pred=%0d score=%0d want pred=%0d score=%0d", i, p, s, ep, es);
      end
      if (lat != LAT) begin
        n_bad++;
        $display("FAIL b2b_latency i=%0d got %0d want %0d", i, lat, LAT);
      end
      if (i > 0) begin
        n_cmp++;
        if (cyc - prev != PERIOD) begin
          n_bad++;
          $display("FAIL b2b_period i=%0d got %0d want %0d", i, cyc - prev, PERIOD);
        end
      end
      prev = cyc;
    end
  endtask

  initial begin
    iv = '0;
    ordy = '1;
    for (int k = 0; k < 4; k++) feat[k] = '0;
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b0;
    @(negedge clk);
    test_basic;
    test_tie;
    test_zero;
    test_stall;
    test_abort;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout after %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule
